// File: rtl/rec_qp_ctrl.sv
// rec_qp_ctrl: per-TU QP scheduler for rec_tq; walks Y,U,V and emits qp/per/rem.
// Ports: clk, rstn, start_i/qp_i/comp_en_i in; qp_valid_o/qp_ready_i handshake;
//   qp_sel_o, qp_o, qp_per_o, qp_rem_o, busy_o, done_o out.
// Option: REC_QP_CHROMA_OFFSET_EN adds cb_qp_offset_i / cr_qp_offset_i.

`ifndef TYPE_Y
`define TYPE_Y 2'd0
`endif
`ifndef TYPE_U
`define TYPE_U 2'd1
`endif
`ifndef TYPE_V
`define TYPE_V 2'd2
`endif

module rec_qp_ctrl #(
  parameter int QP_W   = 6,
  parameter int QP_MAX = 51
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [QP_W-1:0]   qp_i,
  input  logic [2:0]        comp_en_i,
`ifdef REC_QP_CHROMA_OFFSET_EN
  input  logic signed [4:0] cb_qp_offset_i,
  input  logic signed [4:0] cr_qp_offset_i,
`endif
  output logic              qp_valid_o,
  input  logic              qp_ready_i,
  output logic [1:0]        qp_sel_o,
  output logic [QP_W-1:0]   qp_o,
  output logic [3:0]        qp_per_o,
  output logic [2:0]        qp_rem_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    MAP,
    DIV,
    OUT,
    DONE
  } state_t;

  localparam logic [QP_W-1:0] QMAX = QP_W'(QP_MAX);

  state_t          state;
  logic [QP_W-1:0] qpb;
  logic [2:0]      mask;
  logic [2:0]      pick;
  logic [1:0]      sel;
  logic [QP_W-1:0] cur_qp;
  logic [QP_W-1:0] rem;
  logic [3:0]      per;

`ifdef REC_QP_CHROMA_OFFSET_EN
  logic signed [4:0] cb_off;
  logic signed [4:0] cr_off;
`endif

  logic [4:0]             off;
  logic signed [QP_W+1:0] qp_sum;
  logic [QP_W-1:0]        qp_chr;
  logic [QP_W-1:0]        qp_comp;

  // HEVC 4:2:0 QpC table. Between 34 and 43 the table
  // steps by one every two QPs, i.e. (q>>1)+16.
  function automatic logic [QP_W-1:0] qpc(
    input logic [QP_W-1:0] q
  );
    if (q < QP_W'(30)) return q;
    if (q < QP_W'(34)) return q - QP_W'(1);
    if (q < QP_W'(44)) return (q >> 1) + QP_W'(16);
    return q - QP_W'(6);
  endfunction

  always_comb begin
    off = '0;
`ifdef REC_QP_CHROMA_OFFSET_EN
    off = pick[1] ? cb_off : cr_off;
`endif
    qp_sum = $signed({2'b00, qpb})
           + $signed({{(QP_W-3){off[4]}}, off});
    if (qp_sum[QP_W+1])
      qp_chr = '0;
    else if (qp_sum > $signed({2'b00, QMAX}))
      qp_chr = QMAX;
    else
      qp_chr = qp_sum[QP_W-1:0];
    qp_comp = pick[0] ? qpb : qpc(qp_chr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      qpb        <= '0;
      mask       <= '0;
      pick       <= '0;
      sel        <= '0;
      cur_qp     <= '0;
      rem        <= '0;
      per        <= '0;
`ifdef REC_QP_CHROMA_OFFSET_EN
      cb_off     <= '0;
      cr_off     <= '0;
`endif
      qp_valid_o <= 1'b0;
      qp_sel_o   <= '0;
      qp_o       <= '0;
      qp_per_o   <= '0;
      qp_rem_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            qpb    <= (qp_i > QMAX) ? QMAX : qp_i;
            mask   <= comp_en_i;
`ifdef REC_QP_CHROMA_OFFSET_EN
            cb_off <= cb_qp_offset_i;
            cr_off <= cr_qp_offset_i;
`endif
            busy_o <= 1'b1;
            state  <= SEL;
          end
        end
        SEL: begin
          priority case (1'b1)
            mask[0]: begin
              pick  <= 3'b001;
              sel   <= `TYPE_Y;
              state <= MAP;
            end
            mask[1]: begin
              pick  <= 3'b010;
              sel   <= `TYPE_U;
              state <= MAP;
            end
            mask[2]: begin
              pick  <= 3'b100;
              sel   <= `TYPE_V;
              state <= MAP;
            end
            default: begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          endcase
        end
        MAP: begin
          cur_qp <= qp_comp;
          rem    <= qp_comp;
          per    <= '0;
          state  <= DIV;
        end
        DIV: begin
          // Repeated subtraction: per+1 cycles.
          if (rem >= QP_W'(6)) begin
            rem <= rem - QP_W'(6);
            per <= per + 4'd1;
          end else begin
            qp_valid_o <= 1'b1;
            qp_sel_o   <= sel;
            qp_o       <= cur_qp;
            qp_per_o   <= per;
            qp_rem_o   <= rem[2:0];
            state      <= OUT;
          end
        end
        OUT: begin
          if (qp_ready_i) begin
            qp_valid_o <= 1'b0;
            mask       <= mask & ~pick;
            state      <= SEL;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rec_qp_ctrl.sv
// tb_rec_qp_ctrl: directed self-checking bench for rec_qp_ctrl.
// Hand-computed QP/per/rem vectors, latency, stall, and reset cases.

`ifndef TYPE_Y
`define TYPE_Y 2'd0
`endif
`ifndef TYPE_U
`define TYPE_U 2'd1
`endif
`ifndef TYPE_V
`define TYPE_V 2'd2
`endif

module tb_rec_qp_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic [5:0] qp_i;
  logic [2:0] comp_en_i;
  logic       qp_valid_o;
  logic       qp_ready_i;
  logic [1:0] qp_sel_o;
  logic [5:0] qp_o;
  logic [3:0] qp_per_o;
  logic [2:0] qp_rem_o;
  logic       busy_o;
  logic       done_o;
`ifdef REC_QP_CHROMA_OFFSET_EN
  logic signed [4:0] cb_off;
  logic signed [4:0] cr_off;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rec_qp_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .qp_i           (qp_i),
    .comp_en_i      (comp_en_i),
`ifdef REC_QP_CHROMA_OFFSET_EN
    .cb_qp_offset_i (cb_off),
    .cr_qp_offset_i (cr_off),
`endif
    .qp_valid_o     (qp_valid_o),
    .qp_ready_i     (qp_ready_i),
    .qp_sel_o       (qp_sel_o),
    .qp_o           (qp_o),
    .qp_per_o       (qp_per_o),
    .qp_rem_o       (qp_rem_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tu(int qp, logic [2:0] en);
    qp_i      = 6'(qp);
    comp_en_i = en;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_valid(string tag, output int n);
    n = 0;
    while (!qp_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!qp_valid_o) check({tag, "_valid_to"}, 0, 1);
  endtask

  task automatic expect_res(string tag, logic [1:0] s,
                            int q, int p, int r,
                            output int n);
    wait_valid(tag, n);
    check({tag, "_sel"}, qp_sel_o, s);
    check({tag, "_qp"},  qp_o, q);
    check({tag, "_per"}, qp_per_o, p);
    check({tag, "_rem"}, qp_rem_o, r);
    if (qp_ready_i) tick();
  endtask

  task automatic wait_done(string tag, output int n);
    n = 0;
    while (!done_o && n < 50) begin
      check({tag, "_novalid"}, qp_valid_o, 0);
      tick();
      n++;
    end
    check({tag, "_done"}, done_o, 1);
    tick();
    check({tag, "_pulse"}, done_o, 0);
    check({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    int n;
    rstn       = 1'b0;
    start_i    = 1'b0;
    qp_i       = '0;
    comp_en_i  = '0;
    qp_ready_i = 1'b1;
`ifdef REC_QP_CHROMA_OFFSET_EN
    cb_off     = '0;
    cr_off     = '0;
`endif
    #1;
    check("rst_valid", qp_valid_o, 0);
    check("rst_sel",   qp_sel_o, 0);
    check("rst_qp",    qp_o, 0);
    check("rst_per",   qp_per_o, 0);
    check("rst_rem",   qp_rem_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_done",  done_o, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Y only, qp 0: valid 4 cycles, done 6 cycles after start
    start_tu(0, 3'b001);
    check("lat_busy", busy_o, 1);
    expect_res("lat_y", `TYPE_Y, 0, 0, 0, n);
    check("lat_valid_cyc", n, 3);
    wait_done("lat", n);
    check("lat_done_cyc", n, 1);

    // qp 32, all components, back-to-back start
    start_tu(32, 3'b111);
    expect_res("q32_y", `TYPE_Y, 32, 5, 2, n);
    check("q32_y_cyc", n, 8);
    expect_res("q32_u", `TYPE_U, 31, 5, 1, n);
    expect_res("q32_v", `TYPE_V, 31, 5, 1, n);
    wait_done("q32", n);

    // qp 60 clipped to 51; Y divide lasts 9 cycles
    start_tu(60, 3'b111);
    expect_res("q60_y", `TYPE_Y, 51, 8, 3, n);
    check("q60_y_cyc", n, 11);
    expect_res("q60_u", `TYPE_U, 45, 7, 3, n);
    expect_res("q60_v", `TYPE_V, 45, 7, 3, n);
    wait_done("q60", n);

    // Y only and empty mask
    start_tu(22, 3'b001);
    expect_res("q22_y", `TYPE_Y, 22, 3, 4, n);
    wait_done("q22", n);
    start_tu(22, 3'b000);
    wait_done("empty", n);
    check("empty_done_cyc", n, 1);

    // qp 45, U stalled 5 cycles, stray start ignored
    start_tu(45, 3'b111);
    expect_res("q45_y", `TYPE_Y, 45, 7, 3, n);
    qp_ready_i = 1'b0;
    expect_res("q45_u", `TYPE_U, 39, 6, 3, n);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        qp_i      = 6'd10;
        comp_en_i = 3'b001;
        start_i   = 1'b1;
      end
      tick();
      start_i = 1'b0;
      check("stall_valid", qp_valid_o, 1);
      check("stall_sel",   qp_sel_o, `TYPE_U);
      check("stall_qp",    qp_o, 39);
      check("stall_per",   qp_per_o, 6);
      check("stall_rem",   qp_rem_o, 3);
    end
    qp_ready_i = 1'b1;
    tick();
    check("stall_drop", qp_valid_o, 0);
    expect_res("q45_v", `TYPE_V, 39, 6, 3, n);
    wait_done("q45", n);
    tick();
    tick();
    check("ignored_valid", qp_valid_o, 0);
    check("ignored_busy",  busy_o, 0);

    // reset during V's divide
    start_tu(32, 3'b111);
    expect_res("r_y", `TYPE_Y, 32, 5, 2, n);
    expect_res("r_u", `TYPE_U, 31, 5, 1, n);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("mid_valid", qp_valid_o, 0);
    check("mid_sel",   qp_sel_o, 0);
    check("mid_qp",    qp_o, 0);
    check("mid_per",   qp_per_o, 0);
    check("mid_rem",   qp_rem_o, 0);
    check("mid_busy",  busy_o, 0);
    check("mid_done",  done_o, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_done", done_o, 0);
    start_tu(0, 3'b001);
    expect_res("post_y", `TYPE_Y, 0, 0, 0, n);
    wait_done("post", n);

`ifdef REC_QP_CHROMA_OFFSET_EN
    cb_off = 5'sd3;
    cr_off = -5'sd12;
    start_tu(40, 3'b110);
    cb_off = '0;
    cr_off = '0;
    expect_res("off_u", `TYPE_U, 37, 6, 1, n);
    expect_res("off_v", `TYPE_V, 28, 4, 4, n);
    wait_done("off", n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
